mdu_e: RTL and testbench
========================

Name: mdu_e

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline with precise exceptions.
- Sits directly downstream of the D/E pipeline register and consumes its E-side outputs: operands RD1_E/RD2_E (after forwarding), the Multiply_E/Divide_E class flags and a decoded MD opcode.
- Owns the architectural HI/LO registers and models the multi-cycle latency with a busy counter.
- Provides Start/Busy to the hazard unit, which stalls D-stage MD instructions.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (and madd/maddu when enabled); must be at least 1
DIV_CYCLES, 10, busy duration for div/divu; must be at least 1

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset; clears HI, LO and counter
MdOp_E  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; all other codes treated as none
Multiply_E  input  1  class flag from D/E register; qualifies opcodes 1, 2, 7, 8
Divide_E  input  1  class flag from D/E register; qualifies opcodes 3, 4
SrcA_E  input  32  forwarded rs value
SrcB_E  input  32  forwarded rt value
req  input  1  exception/interrupt taken this cycle; suppresses any new MD state change
Start  output  1  combinational; a mult/div is being issued this cycle
Busy  output  1  registered; an operation is in flight
Hi  output  32  architectural HI
Lo  output  32  architectural LO

Behaviour:
- Reset, asserted asynchronously while reset is low: Hi=0, Lo=0, Busy=0, counter=0, latched operands=0. Start is combinational and is 0 whenever MdOp_E=0.
- Start = !req && !Busy && ((MdOp_E in {1,2,7,8} && Multiply_E) || (MdOp_E in {3,4} && Divide_E)).
- Start cycle edge:
  - Latch the op and both operands.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Busy rises at this edge.
- Busy = (counter != 0). The counter decrements once per cycle.
- On the edge where the counter goes 1->0, write HI/LO:
  - mult: {Hi,Lo} = signed(A)*signed(B), 64-bit.
  - multu: {Hi,Lo} = A*B, unsigned 64-bit.
  - div: Lo = signed quotient, truncated toward zero; Hi = remainder, sign of dividend.
  - divu: Lo = A/B, Hi = A%B, unsigned.
- Divisor 0 (div/divu): Busy runs the full DIV_CYCLES; Hi and Lo are left unchanged.
- div with 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- mthi/mtlo:
  - Take effect at the next edge when !req && !Busy (Hi<=SrcA_E or Lo<=SrcA_E); Busy is unaffected.
  - While Busy they are ignored; the hazard unit guarantees they never arrive then.
- Latency: with a start edge at T, Busy is high in cycles T+1..T+N and Hi/Lo are valid from T+N. mfhi/mflo consumers must stall while Start||Busy.
- Issue while Busy: never sourced by the hazard unit. If it occurs, it is ignored with no latch and no counter reload.
- req=1 in the issue cycle: Start=0 and nothing is latched. mthi/mtlo are also dropped.
- req during an in-flight op: the op continues and commits normally.
- Reset mid-operation: the op is aborted and Hi/Lo are cleared.
- Operand latching: results depend only on latched values. SrcA_E/SrcB_E changing after the start edge has no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: opcodes 7 (madd) and 8 (maddu) are legal.
  - At completion, {Hi,Lo} = {Hi,Lo} + product (signed or unsigned), mod 2^64.
  - The accumulate uses Hi/Lo as they stand at completion.
  - Latency is MULT_CYCLES.
- Undefined: opcodes 7 and 8 are treated as none (Start=0, no state change) and the 64-bit adder is not synthesised.

Test Plan:
- Reset release, then mult A=0xFFFFFFFE, B=3, MULT_CYCLES=5 -> Start=1 on the issue cycle; Busy high exactly 5 cycles; afterwards Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles Hi=0xFFFFFFFE, Lo=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; then Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Follow with divu 7/0 -> Busy for 10 cycles; Hi/Lo unchanged.
- mthi 0x1234 then mtlo 0x5678 on consecutive cycles -> Hi=0x1234, Lo=0x5678 one edge after each; Busy stays 0.
- mult issued with req=1 -> Start=0, Busy stays 0, Hi/Lo unchanged. Next, a mult issued cleanly, then req pulsed mid-flight -> the result still commits. Drive reset low mid-div -> Busy=0, Hi=Lo=0 immediately.
- With MDU_MADD_EN: Hi:Lo=0x00000000_FFFFFFFF, then maddu 1*1 -> Hi=1, Lo=0. Without it: opcode 7 gives Start=0 and no change.

Source files
------------

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit: owns HI/LO, models latency with a busy counter.
// Optional madd/maddu accumulate support is built when MDU_MADD_EN is defined.
module mdu_e #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MdOp_E,
   input  logic        Multiply_E,
   input  logic        Divide_E,
   input  logic [31:0] SrcA_E,
   input  logic [31:0] SrcB_E,
   input  logic        req,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] cnt;
   logic [3:0]    op_q;
   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;

   logic          is_mul_op;
   logic          is_div_op;
   logic          commit;
   logic [63:0]   hilo_next;

   logic signed [63:0] ext_a;
   logic signed [63:0] ext_b;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        mag_a;
   logic [31:0]        mag_b;
   logic [31:0]        uq_mag;
   logic [31:0]        ur_mag;
   logic [31:0]        sq;
   logic [31:0]        sr;

   always_comb begin
      is_mul_op = (MdOp_E == OP_MULT) || (MdOp_E == OP_MULTU);
`ifdef MDU_MADD_EN
      is_mul_op = is_mul_op || (MdOp_E == OP_MADD) || (MdOp_E == OP_MADDU);
`endif
      is_div_op = (MdOp_E == OP_DIV) || (MdOp_E == OP_DIVU);
   end

   assign Busy   = (cnt != '0);
   assign Start  = !req && !Busy && ((is_mul_op && Multiply_E) || (is_div_op && Divide_E));
   assign commit = (cnt == CW'(1));
   assign Hi     = hi_q;
   assign Lo     = lo_q;

   // Signed divide is done on magnitudes so 0x80000000 / -1 needs no special case.
   always_comb begin
      ext_a  = {{32{a_q[31]}}, a_q};
      ext_b  = {{32{b_q[31]}}, b_q};
      prod_s = ext_a * ext_b;
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      mag_a  = a_q[31] ? (32'd0 - a_q) : a_q;
      mag_b  = b_q[31] ? (32'd0 - b_q) : b_q;
      uq_mag = '0;
      ur_mag = '0;
      if (b_q != 32'd0) begin
         uq_mag = mag_a / mag_b;
         ur_mag = mag_a % mag_b;
      end
      sq = (a_q[31] ^ b_q[31]) ? (32'd0 - uq_mag) : uq_mag;
      sr = a_q[31] ? (32'd0 - ur_mag) : ur_mag;
   end

   always_comb begin
      hilo_next = {hi_q, lo_q};
      case (op_q)
         OP_MULT:  hilo_next = prod_s;
         OP_MULTU: hilo_next = prod_u;
         OP_DIV:   if (b_q != 32'd0) hilo_next = {sr, sq};
         OP_DIVU:  if (b_q != 32'd0) hilo_next = {a_q % b_q, a_q / b_q};
`ifdef MDU_MADD_EN
         OP_MADD:  hilo_next = {hi_q, lo_q} + prod_s;
         OP_MADDU: hilo_next = {hi_q, lo_q} + prod_u;
`endif
         default:  hilo_next = {hi_q, lo_q};
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else if (Start) begin
         op_q <= MdOp_E;
         a_q  <= SrcA_E;
         b_q  <= SrcB_E;
         cnt  <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (Busy) begin
         cnt <= cnt - CW'(1);
         if (commit) begin
            hi_q <= hilo_next[63:32];
            lo_q <= hilo_next[31:0];
         end
      end else if (!req) begin
         // Moves to HI/LO only land when nothing is in flight.
         if (MdOp_E == OP_MTHI) hi_q <= SrcA_E;
         if (MdOp_E == OP_MTLO) lo_q <= SrcA_E;
      end
   end

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed scenarios plus randomized ops against a reference model.
module tb_mdu_e;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  MdOp_E = '0;
   logic        Multiply_E = 1'b0;
   logic        Divide_E = 1'b0;
   logic [31:0] SrcA_E = '0;
   logic [31:0] SrcB_E = '0;
   logic        req = 1'b0;
   logic        Start;
   logic        Busy;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int checks = 0;
   int failures = 0;
   logic [63:0] hilo_m = '0;
   logic [63:0] exp_q[$];

   mdu_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .MdOp_E(MdOp_E), .Multiply_E(Multiply_E),
      .Divide_E(Divide_E), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .req(req),
      .Start(Start), .Busy(Busy), .Hi(Hi), .Lo(Lo)
   );

   always #5 clk = ~clk;

   // Reference model: architectural HI/LO after one MD instruction.
   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hilo);
      int sa, sb;
      longint ps;
      logic [63:0] pu;
      sa = a;
      sb = b;
      ps = longint'(sa) * longint'(sb);
      pu = 64'(a) * 64'(b);
      case (op)
         4'd1: return ps;
         4'd2: return pu;
         4'd3: begin
            if (b == 0) return hilo;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         4'd4: return (b == 0) ? hilo : {a % b, a / b};
         4'd5: return {a, hilo[31:0]};
         4'd6: return {hilo[63:32], a};
`ifdef MDU_MADD_EN
         4'd7: return hilo + ps;
         4'd8: return hilo + pu;
`endif
         default: return hilo;
      endcase
   endfunction

   function automatic int busy_len(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2) return MULT_N;
`ifdef MDU_MADD_EN
      if (op == 4'd7 || op == 4'd8) return MULT_N;
`endif
      if (op == 4'd3 || op == 4'd4) return DIV_N;
      return 0;
   endfunction

   task automatic clear_inputs();
      MdOp_E = '0; Multiply_E = 1'b0; Divide_E = 1'b0; req = 1'b0;
      SrcA_E = $urandom; SrcB_E = $urandom;
   endtask

   // Drive one op for a single cycle, then count busy cycles (bounded).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, output logic st, output int busy_n);
      @(negedge clk);
      MdOp_E = op;
      Multiply_E = (op == 4'd1 || op == 4'd2 || op == 4'd7 || op == 4'd8);
      Divide_E = (op == 4'd3 || op == 4'd4);
      SrcA_E = a; SrcB_E = b; req = rq;
      #1 st = Start;
      @(posedge clk); #1;
      clear_inputs();
      busy_n = 0;
      for (int i = 0; i < 40 && Busy; i++) begin
         busy_n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (Hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", Hi); end
      if (Lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", Lo); end
      if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
      if (Start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", Start); end
      @(negedge clk);
      reset = 1'b1;
      hilo_m = '0;
   endtask

   task automatic test_mult();
      logic st; int n;
      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, st, n);
      checks += 4;
      if (st !== 1'b1) begin failures++; $display("FAIL mult_start got=%b exp=1", st); end
      if (n != MULT_N) begin failures++; $display("FAIL mult_busy got=%0d exp=%0d", n, MULT_N); end
      if (Hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", Hi); end
      if (Lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", Lo); end
      run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st, n);
      checks += 3;
      if (n != MULT_N) begin failures++; $display("FAIL multu_busy got=%0d exp=%0d", n, MULT_N); end
      if (Hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", Hi); end
      if (Lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", Lo); end
      hilo_m = {32'hFFFF_FFFE, 32'h0000_0001};
   endtask

   task automatic test_div();
      logic st; int n;
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, st, n);
      checks += 3;
      if (n != DIV_N) begin failures++; $display("FAIL div_busy got=%0d exp=%0d", n, DIV_N); end
      if (Lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", Lo); end
      if (Hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", Hi); end
      run_op(4'd4, 32'd7, 32'd0, 1'b0, st, n);
      checks += 3;
      if (n != DIV_N) begin failures++; $display("FAIL divz_busy got=%0d exp=%0d", n, DIV_N); end
      if (Lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL divz_lo got=%h exp=fffffffd", Lo); end
      if (Hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_hi got=%h exp=ffffffff", Hi); end
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st, n);
      checks += 2;
      if (Lo !== 32'h8000_0000) begin failures++; $display("FAIL divovf_lo got=%h exp=80000000", Lo); end
      if (Hi !== 32'h0) begin failures++; $display("FAIL divovf_hi got=%h exp=0", Hi); end
      hilo_m = {32'h0, 32'h8000_0000};
   endtask

   task automatic test_mthi_mtlo();
      @(negedge clk);
      MdOp_E = 4'd5; SrcA_E = 32'h1234;
      @(posedge clk); #1;
      checks += 2;
      if (Hi !== 32'h1234) begin failures++; $display("FAIL mthi_hi got=%h exp=00001234", Hi); end
      if (Busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", Busy); end
      MdOp_E = 4'd6; SrcA_E = 32'h5678;
      @(posedge clk); #1;
      checks += 3;
      if (Lo !== 32'h5678) begin failures++; $display("FAIL mtlo_lo got=%h exp=00005678", Lo); end
      if (Hi !== 32'h1234) begin failures++; $display("FAIL mtlo_hi got=%h exp=00001234", Hi); end
      if (Busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b exp=0", Busy); end
      clear_inputs();
      hilo_m = {32'h1234, 32'h5678};
   endtask

   task automatic test_req();
      logic st; int n;
      run_op(4'd1, 32'd7, 32'd9, 1'b1, st, n);
      checks += 3;
      if (st !== 1'b0) begin failures++; $display("FAIL req_start got=%b exp=0", st); end
      if (n != 0) begin failures++; $display("FAIL req_busy got=%0d exp=0", n); end
      if ({Hi, Lo} !== hilo_m) begin failures++; $display("FAIL req_hilo got=%h exp=%h", {Hi, Lo}, hilo_m); end
      run_op(4'd6, 32'hDEAD, 32'd0, 1'b1, st, n);
      checks += 1;
      if ({Hi, Lo} !== hilo_m) begin failures++; $display("FAIL req_mtlo got=%h exp=%h", {Hi, Lo}, hilo_m); end
      @(negedge clk);
      MdOp_E = 4'd1; Multiply_E = 1'b0; SrcA_E = 32'd3; SrcB_E = 32'd3;
      #1;
      checks += 1;
      if (Start !== 1'b0) begin failures++; $display("FAIL noflag_start got=%b exp=0", Start); end
      clear_inputs();
      // Clean mult, with req, a stray issue and a stray mthi injected mid-flight.
      @(negedge clk);
      MdOp_E = 4'd1; Multiply_E = 1'b1; SrcA_E = 32'h10; SrcB_E = 32'h20;
      @(posedge clk); #1;
      clear_inputs();
      n = 0;
      for (int i = 0; i < 40 && Busy; i++) begin
         n++;
         if (n == 2) begin
            req = 1'b1; MdOp_E = 4'd2; Multiply_E = 1'b1;
            SrcA_E = 32'hFFFF_FFFF; SrcB_E = 32'hFFFF_FFFF;
         end else if (n == 3) begin
            clear_inputs(); MdOp_E = 4'd5; SrcA_E = 32'hBAD0;
         end else begin
            clear_inputs();
         end
         @(posedge clk); #1;
      end
      clear_inputs();
      checks += 3;
      if (n != MULT_N) begin failures++; $display("FAIL inflight_busy got=%0d exp=%0d", n, MULT_N); end
      if (Hi !== 32'h0) begin failures++; $display("FAIL inflight_hi got=%h exp=0", Hi); end
      if (Lo !== 32'h200) begin failures++; $display("FAIL inflight_lo got=%h exp=00000200", Lo); end
      hilo_m = {32'h0, 32'h200};
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      MdOp_E = 4'd4; Divide_E = 1'b1; SrcA_E = 32'd100; SrcB_E = 32'd7;
      @(posedge clk); #1;
      clear_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks += 3;
      if (Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", Busy); end
      if (Hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", Hi); end
      if (Lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", Lo); end
      @(negedge clk);
      reset = 1'b1;
      hilo_m = '0;
   endtask

   task automatic test_madd();
      logic st; int n;
      run_op(4'd5, 32'h0, 32'h0, 1'b0, st, n);
      run_op(4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0, st, n);
      hilo_m = {32'h0, 32'hFFFF_FFFF};
      run_op(4'd8, 32'd1, 32'd1, 1'b0, st, n);
`ifdef MDU_MADD_EN
      checks += 4;
      if (st !== 1'b1) begin failures++; $display("FAIL maddu_start got=%b exp=1", st); end
      if (n != MULT_N) begin failures++; $display("FAIL maddu_busy got=%0d exp=%0d", n, MULT_N); end
      if (Hi !== 32'h1) begin failures++; $display("FAIL maddu_hi got=%h exp=1", Hi); end
      if (Lo !== 32'h0) begin failures++; $display("FAIL maddu_lo got=%h exp=0", Lo); end
      hilo_m = {32'h1, 32'h0};
`else
      checks += 2;
      if (st !== 1'b0) begin failures++; $display("FAIL maddu_start got=%b exp=0", st); end
      if ({Hi, Lo} !== hilo_m) begin failures++; $display("FAIL maddu_hilo got=%h exp=%h", {Hi, Lo}, hilo_m); end
`endif
      run_op(4'd7, 32'hFFFF_FFFF, 32'd2, 1'b0, st, n);
      checks += 2;
      if (n != busy_len(4'd7)) begin failures++; $display("FAIL madd_busy got=%0d exp=%0d", n, busy_len(4'd7)); end
      hilo_m = model(4'd7, 32'hFFFF_FFFF, 32'd2, hilo_m);
      if ({Hi, Lo} !== hilo_m) begin failures++; $display("FAIL madd_hilo got=%h exp=%h", {Hi, Lo}, hilo_m); end
   endtask

   task automatic test_random();
      logic st; int n;
      logic [3:0] op;
      logic [31:0] a, b;
      logic [63:0] exp;
      for (int k = 0; k < 30; k++) begin
         op = 4'($urandom_range(1, 6));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         exp_q.push_back(model(op, a, b, hilo_m));
         run_op(op, a, b, 1'b0, st, n);
         exp = exp_q.pop_front();
         hilo_m = exp;
         checks += 2;
         if (n != busy_len(op)) begin
            failures++; $display("FAIL rand_busy op=%0d got=%0d exp=%0d", op, n, busy_len(op));
         end
         if ({Hi, Lo} !== exp) begin
            failures++; $display("FAIL rand_hilo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, {Hi, Lo}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_req();
      test_reset_mid();
      test_madd();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
